// File: rtl/matmul_tile_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_tile_scheduler_pkg                                       |
// | Purpose  : Shared types and constants for the tiled matrix-multiply        |
// |            scheduler: tile geometry, block-count struct, FSM state enum.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif

package matmul_tile_scheduler_pkg;

    localparam int TILE       = 8;
    localparam int TILE_LOG2  = 3;
    localparam int BLK_WIDTH  = `DIM_WIDTH - TILE_LOG2;

    // Matrix dimensions expressed in 8x8 blocks.
    typedef struct packed {
        logic [BLK_WIDTH-1:0] n_a1;
        logic [BLK_WIDTH-1:0] n_k;
        logic [BLK_WIDTH-1:0] n_b2;
    } block_dim_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_MULT = 3'd3,
        ST_ACCUM     = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/matmul_tile_scheduler_tile_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tile_addr_gen                                                   |
// | Purpose  : Combinational tile address generation for the scheduler.       |
// |   blk_i, blk_j, blk_k : current tile/step indices (in blocks)              |
// |   stride_a, stride_b  : row strides of A and B (dimA2, dimB2)              |
// |   addr_a/b/c          : matrix base addresses                              |
// |   base_A, base_B      : operand tile bases; wb_addr : output tile base     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tile_addr_gen
    import matmul_tile_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DIM_WIDTH  = `DIM_WIDTH
) (
    input  logic [BLK_WIDTH-1:0]  blk_i,
    input  logic [BLK_WIDTH-1:0]  blk_j,
    input  logic [BLK_WIDTH-1:0]  blk_k,
    input  logic [DIM_WIDTH-1:0]  stride_a,
    input  logic [DIM_WIDTH-1:0]  stride_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [ADDR_WIDTH-1:0] addr_c,
    output logic [ADDR_WIDTH-1:0] base_A,
    output logic [ADDR_WIDTH-1:0] base_B,
    output logic [ADDR_WIDTH-1:0] wb_addr
);

    // (8*blk)*stride as a shift-add over the bits of the block index; the
    // index is narrow so this stays a short adder chain, no multiplier.
    function automatic logic [ADDR_WIDTH-1:0] f_blk_mul(
        input logic [BLK_WIDTH-1:0] blk,
        input logic [DIM_WIDTH-1:0] stride
    );
        logic [ADDR_WIDTH-1:0] w_acc;
        logic [ADDR_WIDTH-1:0] w_row;
        w_acc = '0;
        w_row = ADDR_WIDTH'(stride) << TILE_LOG2;
        for (int b = 0; b < BLK_WIDTH; b++) begin
            if (blk[b]) begin
                w_acc = w_acc + (w_row << b);
            end
        end
        return w_acc;
    endfunction

    logic [ADDR_WIDTH-1:0] w_off_j;
    logic [ADDR_WIDTH-1:0] w_off_k;

    assign w_off_j = ADDR_WIDTH'({blk_j, 3'b000});
    assign w_off_k = ADDR_WIDTH'({blk_k, 3'b000});

    // All sums wrap modulo 2^ADDR_WIDTH by construction.
    assign base_A  = addr_a + f_blk_mul(blk_i, stride_a) + w_off_k;
    assign base_B  = addr_b + f_blk_mul(blk_k, stride_b) + w_off_j;
    assign wb_addr = addr_c + f_blk_mul(blk_i, stride_b) + w_off_j;

endmodule

`default_nettype wire

// File: rtl/matmul_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_tile_scheduler                                           |
// | Purpose  : Sequences C = A x B as 8x8 tile jobs on the block multiplier.   |
// |   start/dims/addrs   : op request (sampled in IDLE only)                   |
// |   busy/done/err      : status; done pulses once, err valid with done       |
// |   mult_start/base_*  : multiplier job request and operand tile bases       |
// |   mult_done          : multiplier result valid                             |
// |   acc_en/acc_clear   : accumulator strobe; clear on the first k step       |
// |   wb_valid/wb_addr/wb_ready : tile writeback handshake                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matmul_tile_scheduler
    import matmul_tile_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DIM_WIDTH  = `DIM_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  dimA1,
    input  logic [DIM_WIDTH-1:0]  dimA2,
    input  logic [DIM_WIDTH-1:0]  dimB1,
    input  logic [DIM_WIDTH-1:0]  dimB2,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [ADDR_WIDTH-1:0] addrC,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mult_start,
    output logic [ADDR_WIDTH-1:0] base_A,
    output logic [ADDR_WIDTH-1:0] base_B,
    output logic [DIM_WIDTH-1:0]  dim_col_A,
    output logic [DIM_WIDTH-1:0]  dim_col_B,
    input  logic                  mult_done,
    output logic                  acc_en,
    output logic                  acc_clear,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  wb_ready
);

    state_t                r_state;
    state_t                w_next;
    logic [DIM_WIDTH-1:0]  r_dim_a1;
    logic [DIM_WIDTH-1:0]  r_dim_a2;
    logic [DIM_WIDTH-1:0]  r_dim_b1;
    logic [DIM_WIDTH-1:0]  r_dim_b2;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_c;
    block_dim_t            r_blk;
    logic [BLK_WIDTH-1:0]  r_i;
    logic [BLK_WIDTH-1:0]  r_j;
    logic [BLK_WIDTH-1:0]  r_k;
    logic                  r_done;
    logic                  r_err;

    logic w_dim_err;
    logic w_last_i;
    logic w_last_j;
    logic w_last_k;

    // Every dim must be a nonzero multiple of 8 and the inner dims must agree.
    assign w_dim_err = (|r_dim_a1[TILE_LOG2-1:0]) || (|r_dim_a2[TILE_LOG2-1:0]) ||
                       (|r_dim_b1[TILE_LOG2-1:0]) || (|r_dim_b2[TILE_LOG2-1:0]) ||
                       (r_dim_a1 == '0) || (r_dim_a2 == '0) ||
                       (r_dim_b1 == '0) || (r_dim_b2 == '0) ||
                       (r_dim_a2 != r_dim_b1);

    assign w_last_i = (r_i == r_blk.n_a1 - 1'b1);
    assign w_last_j = (r_j == r_blk.n_b2 - 1'b1);
    assign w_last_k = (r_k == r_blk.n_k  - 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Registered so they are high exactly while the state is DONE.
            r_done  <= (w_next == ST_DONE);
            r_err   <= (r_state == ST_CHECK) && w_dim_err;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_CHECK;
            ST_CHECK:     w_next = w_dim_err ? ST_DONE : ST_ISSUE;
            ST_ISSUE:     w_next = ST_WAIT_MULT;
            ST_WAIT_MULT: if (mult_done) w_next = ST_ACCUM;
            ST_ACCUM:     w_next = w_last_k ? ST_WRITEBACK : ST_ISSUE;
            ST_WRITEBACK: begin
                if (wb_ready) begin
                    w_next = (w_last_i && w_last_j) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != ST_IDLE);
        mult_start = (r_state == ST_ISSUE);
        acc_en     = (r_state == ST_ACCUM);
        acc_clear  = (r_state == ST_ACCUM) && (r_k == '0);
        wb_valid   = (r_state == ST_WRITEBACK);
        done       = r_done;
        err        = r_err;
        dim_col_A  = r_dim_a2;
        dim_col_B  = r_dim_b2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dim_a1 <= '0;
            r_dim_a2 <= '0;
            r_dim_b1 <= '0;
            r_dim_b2 <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_c <= '0;
            r_blk    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dim_a1   <= dimA1;
                        r_dim_a2   <= dimA2;
                        r_dim_b1   <= dimB1;
                        r_dim_b2   <= dimB2;
                        r_addr_a   <= addrA;
                        r_addr_b   <= addrB;
                        r_addr_c   <= addrC;
                        r_blk.n_a1 <= BLK_WIDTH'(dimA1 >> TILE_LOG2);
                        r_blk.n_k  <= BLK_WIDTH'(dimA2 >> TILE_LOG2);
                        r_blk.n_b2 <= BLK_WIDTH'(dimB2 >> TILE_LOG2);
                    end
                end
                ST_CHECK: begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                ST_ACCUM: begin
                    // k holds at its last value through WRITEBACK.
                    if (!w_last_k) r_k <= r_k + 1'b1;
                end
                ST_WRITEBACK: begin
                    if (wb_ready) begin
                        r_k <= '0;
                        if (w_last_j) begin
                            r_j <= '0;
                            if (!w_last_i) r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_tile_addr_gen (
        .blk_i    (r_i),
        .blk_j    (r_j),
        .blk_k    (r_k),
        .stride_a (r_dim_a2),
        .stride_b (r_dim_b2),
        .addr_a   (r_addr_a),
        .addr_b   (r_addr_b),
        .addr_c   (r_addr_c),
        .base_A   (base_A),
        .base_B   (base_B),
        .wb_addr  (wb_addr)
    );

endmodule

`default_nettype wire

// File: doc/matmul_tile_scheduler.md
# matmul_tile_scheduler

Sequences a large matrix multiply, C = A × B, as a series of 8×8 tile operations on the existing 8×8 block multiplier. For each output tile it walks the shared (k) dimension, issuing one multiplier job per k step and strobing the accumulator on each result. When a tile is complete it hands the tile to the writeback path. It sits between the top-level op decoder (meta_data_t) and the 8×8 multiplier/accumulator datapath.

## Interface
Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH: word-address width.
- DIM_WIDTH, default `DIM_WIDTH: matrix dimension width, in elements.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high (ports `clock`, `reset`).
- clock  in  1  system clock.
- reset  in  1  async active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dimA1, dimA2, dimB1, dimB2  in  DIM_WIDTH each  operand dimensions, in elements.
- addrA, addrB, addrC  in  ADDR_WIDTH each  base addresses of row-major A, B, C.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of the op.
- err  out  1  valid with done; dimension check failed.
- mult_start  out  1  one-cycle job pulse to the multiplier.
- base_A, base_B  out  ADDR_WIDTH  tile base addresses; held from ISSUE until mult_done.
- dim_col_A, dim_col_B  out  DIM_WIDTH  row strides, equal to dimA2 and dimB2.
- mult_done  in  1  multiplier result valid.
- acc_en  out  1  one-cycle accumulate strobe.
- acc_clear  out  1  with acc_en: overwrite the accumulator instead of adding (k == 0).
- wb_valid  out  1  tile ready for writeback.
- wb_addr  out  ADDR_WIDTH  C tile base address.
- wb_ready  in  1  writeback accepted.

## Operation
- Latch on start: dims, bases, and block counts nA1=dimA1>>3, nK=dimA2>>3, nB2=dimB2>>3.
- Error check, evaluated in CHECK: any dim with low 3 bits nonzero, any dim zero, or dimA2≠dimB1. On error go to DONE with err=1; no mult_start is ever issued.
- Loop order: i over 0..nA1-1 (outer), j over 0..nB2-1, k over 0..nK-1 (inner).
- Address generation:
  - base_A = addrA + (8i)·dimA2 + 8k
  - base_B = addrB + (8k)·dimB2 + 8j
  - wb_addr = addrC + (8i)·dimA2… no: wb_addr = addrC + (8i)·dimB2 + 8j
  - All arithmetic is modulo 2^ADDR_WIDTH; wrap is not flagged.
- States:
  - IDLE: on start → CHECK.
  - CHECK: on error → DONE; otherwise clear i/j/k → ISSUE.
  - ISSUE: assert mult_start for one cycle → WAIT_MULT.
  - WAIT_MULT: on mult_done → ACCUM.
  - ACCUM: assert acc_en, and acc_clear if k==0. If k<nK-1: k++ → ISSUE. Else → WRITEBACK.
  - WRITEBACK: hold wb_valid and wb_addr until wb_ready. On the handshake, k=0 and advance j, then i. If the last tile is done → DONE, otherwise → ISSUE.
  - DONE: done pulse → IDLE.
- start is ignored outside IDLE. mult_done is ignored outside WAIT_MULT.

## Timing
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately; nothing is resumed.
- start → CHECK is 1 cycle; first mult_start appears 2 cycles after start.
- Per k step: 1 (ISSUE) + multiplier latency + 1 (ACCUM) cycles.
- mult_done arriving in the cycle after ISSUE is accepted.
- WRITEBACK lasts at least 1 cycle. wb_valid drops the cycle after wb_ready is sampled high. If wb_ready is already high on entry, the handshake completes in 1 cycle.
- done and err are registered outputs and rise the cycle the state is DONE.

## Structure
- Shared package (add to the existing one):
  - block_dim_t: block-count struct, DIM_WIDTH-3 bits per field.
  - TILE=8 and TILE_LOG2=3 constants.
  - State enum.
- Sub-module tile_addr_gen: combinational base_A/base_B/wb_addr generation from i, j, k, the strides, and the bases. Products are computed with shifts and adds; registering is optional.
- Everything else (FSM and counters) lives in matmul_tile_scheduler.

## Test plan
- 8×8·8×8, bases 0/64/128, mult_done 3 cycles after mult_start → one job (base_A=0, base_B=64), acc_en with acc_clear=1, wb_addr=128, one done pulse, err=0.
- 16×8·8×16 → 4 tiles, each with acc_clear=1. wb_addr sequence is addrC + {0, 8, 128, 136}.
- 8×16·16×8 → one tile, two jobs: base_A addrA+0 then addrA+8; base_B addrB+0 then addrB+64. acc_clear on the first job only; one writeback.
- dimA2=16, dimB1=8 (also repeat with dimA1=12) → done and err high 2 cycles after start; no mult_start, acc_en, or wb_valid.
- wb_ready held low for 5 cycles → wb_valid and wb_addr stable for 5 cycles, no new mult_start. An extra start and a stray mult_done pulse during the stall have no effect.
- reset asserted in WAIT_MULT, then a new 8×8 op started → all outputs 0 at once, idle, and the new op completes normally.
